// File: rtl/leddisplay_arbiter.sv
// Round-robin arbiter sharing one NUM-digit LED segment bus between REQ_N requesters,
// with minimum/maximum ownership time and a blank frame between owners.
module leddisplay_arbiter #(
   parameter int NUM          = 4,
   parameter int REQ_N        = 4,
   parameter int HOLD_CYCLES  = 1000,
   parameter int MAX_CYCLES   = 100000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [REQ_N-1:0]         req,
   input  logic [REQ_N*NUM*8-1:0]   frame_in,
   output logic [REQ_N-1:0]         gnt,
   output logic [2:0]               owner_id,
   output logic                     owner_vld,
   output logic [NUM*8-1:0]         led_out
);

   localparam int          FW         = NUM * 8;
   localparam int          BW         = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
   localparam logic [31:0] HOLD_C     = 32'(HOLD_CYCLES);
   localparam logic [31:0] MAX_C      = 32'(MAX_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_BLANK, S_OWN} state_t;

   state_t           state_q;
   logic [REQ_N-1:0] gnt_q;
   logic [2:0]       owner_q;
   logic [2:0]       last_q;
   logic             vld_q;
   logic [FW-1:0]    led_q;
   logic [BW-1:0]    blank_cnt_q;
   logic [31:0]      hold_cnt_q;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic [REQ_N-1:0] owner_oh;
   logic             owner_req;
   logic             others_req;
   logic             hold_met;
   logic             max_met;
   logic             release_own;
   logic [FW-1:0]    frames [8];
   logic [FW-1:0]    owner_frame;

   genvar g;
   for (g = 0; g < 8; g++) begin : g_frame
      if (g < REQ_N) begin : g_used
         assign frames[g] = frame_in[g*FW +: FW];
      end else begin : g_unused
         assign frames[g] = '0;
      end
   end

   assign owner_oh    = {{(REQ_N-1){1'b0}}, 1'b1} << owner_q;
   assign owner_req   = |(req & owner_oh);
   assign others_req  = |(req & ~owner_oh);
   assign owner_frame = frames[owner_q];
   assign hold_met    = (hold_cnt_q >= HOLD_C);
   assign max_met     = (hold_cnt_q >= MAX_C);

   // A dropped grant (gnt_q == 0 in OWN) commits the owner to release once the hold expires,
   // so a late re-assertion of its request cannot revive the ownership.
   assign release_own = (state_q == S_OWN) &&
                        ((hold_met && (!owner_req || (gnt_q == '0))) || (max_met && others_req));

   // On release the outgoing owner is excluded, so it can only win again after the others.
   logic [2:0]       ptr;
   logic [REQ_N-1:0] cand;
   logic [7:0]       cand8;
   logic [2:0]       idx;
   logic             win_found;
   logic [2:0]       win_id;

   assign ptr   = (state_q == S_OWN) ? owner_q : last_q;
   assign cand  = (state_q == S_OWN) ? (req & ~owner_oh) : req;
   assign cand8 = 8'(cand);

   always_comb begin
      win_found = 1'b0;
      win_id    = 3'd0;
      idx       = 3'd0;
      for (int i = 1; i <= REQ_N; i++) begin
         idx = 3'((int'(ptr) + i) % REQ_N);
         if (!win_found && cand8[idx]) begin
            win_found = 1'b1;
            win_id    = idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         gnt_q       <= '0;
         owner_q     <= 3'd0;
         last_q      <= 3'(REQ_N - 1);
         vld_q       <= 1'b0;
         led_q       <= '0;
         blank_cnt_q <= '0;
         hold_cnt_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               led_q <= '0;
               gnt_q <= '0;
               if (win_found) begin
                  owner_q     <= win_id;
                  vld_q       <= 1'b1;
                  blank_cnt_q <= '0;
                  state_q     <= S_BLANK;
               end
            end
            S_BLANK: begin
               led_q       <= '0;
               gnt_q       <= '0;
               blank_cnt_q <= blank_cnt_q + 1'b1;
               if (blank_cnt_q == BLANK_LAST) begin
                  state_q    <= S_OWN;
                  gnt_q      <= owner_oh;
                  hold_cnt_q <= '0;
               end
            end
            S_OWN: begin
               hold_cnt_q <= sat_inc(hold_cnt_q);
               if (gnt_q != '0) led_q <= owner_frame;
               if (release_own) begin
                  gnt_q  <= '0;
                  led_q  <= '0;
                  last_q <= owner_q;
                  if (win_found) begin
                     owner_q     <= win_id;
                     blank_cnt_q <= '0;
                     state_q     <= S_BLANK;
                  end else begin
                     vld_q   <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end else if (!owner_req && !hold_met) begin
                  gnt_q <= '0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign owner_id  = owner_q;
   assign owner_vld = vld_q;
   assign led_out   = led_q;

endmodule

// File: tb/tb_leddisplay_arbiter.sv
// Directed bench for leddisplay_arbiter: blanking, round-robin order, early drop,
// pre-emption and asynchronous reset, with hand-computed expectations.
module tb_leddisplay_arbiter;

   localparam int NUM   = 4;
   localparam int REQ_N = 4;
   localparam int HOLD  = 1000;
   localparam int MAXC  = 2000;
   localparam int BLANK = 16;

   logic                   clk = 1'b0;
   logic                   rstn = 1'b1;
   logic [REQ_N-1:0]       req = '0;
   logic [REQ_N*NUM*8-1:0] frame_in = '0;
   logic [REQ_N-1:0]       gnt;
   logic [2:0]             owner_id;
   logic                   owner_vld;
   logic [NUM*8-1:0]       led_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   leddisplay_arbiter #(
      .NUM(NUM), .REQ_N(REQ_N), .HOLD_CYCLES(HOLD), .MAX_CYCLES(MAXC), .BLANK_CYCLES(BLANK)
   ) dut (
      .clk(clk), .rstn(rstn), .req(req), .frame_in(frame_in),
      .gnt(gnt), .owner_id(owner_id), .owner_vld(owner_vld), .led_out(led_out)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      req  = '0;
      tick(2);
      rstn = 1'b1;
      tick(1);
   endtask

   task automatic wait_gnt(input int maxc, output int n, output logic ledz);
      n    = 0;
      ledz = 1'b1;
      while (gnt === '0 && n < maxc) begin
         tick(1);
         n++;
         if (gnt === '0 && led_out !== '0) ledz = 1'b0;
      end
   endtask

   task automatic wait_drop(input int maxc, output int n);
      n = 0;
      while (gnt !== '0 && n < maxc) begin
         tick(1);
         n++;
      end
   endtask

   initial begin
      #200_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      logic lz;
      logic held;
      int   order [5];

      #2;
      rstn = 1'b0;
      #1;
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_vld", 64'(owner_vld), 64'd0);
      chk("rst_led", 64'(led_out), 64'd0);
      chk("rst_id", 64'(owner_id), 64'd0);
      tick(2);
      rstn = 1'b1;

      // single requester
      frame_in = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h3F06_5B4F};
      req = 4'b0001;
      tick(1);
      chk("t1_vld", 64'(owner_vld), 64'd1);
      chk("t1_id", 64'(owner_id), 64'd0);
      chk("t1_gnt_blank", 64'(gnt), 64'd0);
      wait_gnt(40, n, lz);
      chk("t1_blank_len", 64'(n), 64'(BLANK));
      chk("t1_blank_led0", 64'(lz), 64'd1);
      chk("t1_gnt", 64'(gnt), 64'h1);
      chk("t1_led_latency", 64'(led_out), 64'd0);
      tick(1);
      chk("t1_led", 64'(led_out), 64'h3F06_5B4F);
      frame_in[31:0] = 32'h0600_0006;
      tick(1);
      chk("t1_led_track", 64'(led_out), 64'h0600_0006);
      tick(MAXC + 100);
      chk("t1_no_preempt", 64'(gnt), 64'h1);

      // round-robin 0,2,0,2 with release after hold
      do_reset();
      frame_in = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
      req = 4'b0101;
      tick(1);
      chk("t2_first_id", 64'(owner_id), 64'd0);
      wait_gnt(40, n, lz);
      chk("t2_first_blank", 64'(n), 64'(BLANK));
      chk("t2_first_gnt", 64'(gnt), 64'h1);
      order = '{0, 2, 0, 2, 0};
      for (int k = 0; k < 4; k++) begin
         tick(1);
         chk("t2_led", 64'(led_out), 64'(frame_in[order[k]*32 +: 32]));
         tick(HOLD + 5);
         req[order[k]] = 1'b0;
         tick(1);
         chk("t2_rel_gnt", 64'(gnt), 64'd0);
         chk("t2_rel_led", 64'(led_out), 64'd0);
         chk("t2_next_id", 64'(owner_id), 64'(order[k+1]));
         req[order[k]] = 1'b1;
         wait_gnt(40, n, lz);
         chk("t2_gap", 64'(n), 64'(BLANK));
         chk("t2_gap_led0", 64'(lz), 64'd1);
         chk("t2_gnt", 64'(gnt), 64'(4'b0001 << order[k+1]));
      end

      // early drop at hold_cnt 10
      do_reset();
      frame_in = {32'h0, 32'h0, 32'hA5A5_0001, 32'h1111_1111};
      req = 4'b0010;
      tick(1);
      chk("t3_id", 64'(owner_id), 64'd1);
      wait_gnt(40, n, lz);
      chk("t3_blank", 64'(n), 64'(BLANK));
      chk("t3_gnt", 64'(gnt), 64'h2);
      tick(1);
      chk("t3_led", 64'(led_out), 64'hA5A5_0001);
      tick(9);
      req = 4'b0000;
      tick(1);
      chk("t3_drop_gnt", 64'(gnt), 64'd0);
      chk("t3_drop_vld", 64'(owner_vld), 64'd1);
      chk("t3_drop_led", 64'(led_out), 64'hA5A5_0001);
      frame_in[63:32] = 32'hDEAD_BEEF;
      n    = 0;
      held = 1'b1;
      while (owner_vld === 1'b1 && n < 2 * HOLD) begin
         tick(1);
         n++;
         if (owner_vld === 1'b1 && led_out !== 32'hA5A5_0001) held = 1'b0;
      end
      chk("t3_hold_len", 64'(n), 64'(HOLD - 10));
      chk("t3_frozen", 64'(held), 64'd1);
      chk("t3_idle_led", 64'(led_out), 64'd0);
      chk("t3_idle_gnt", 64'(gnt), 64'd0);

      // pre-emption at MAX_CYCLES
      do_reset();
      frame_in = {32'h7777_0003, 32'h0, 32'h0, 32'h0000_00FF};
      req = 4'b0001;
      tick(1);
      wait_gnt(40, n, lz);
      chk("t4_gnt0", 64'(gnt), 64'h1);
      tick(50);
      req = 4'b1001;
      wait_drop(3 * MAXC, n);
      chk("t4_preempt_at", 64'(n), 64'(MAXC + 1 - 50));
      chk("t4_next_id", 64'(owner_id), 64'd3);
      chk("t4_vld", 64'(owner_vld), 64'd1);
      chk("t4_blank_led", 64'(led_out), 64'd0);
      wait_gnt(40, n, lz);
      chk("t4_blank", 64'(n), 64'(BLANK));
      chk("t4_gnt3", 64'(gnt), 64'h8);
      tick(1);
      chk("t4_led3", 64'(led_out), 64'h7777_0003);
      tick(HOLD + 5);
      req = 4'b0001;
      tick(1);
      chk("t4_rel3_gnt", 64'(gnt), 64'd0);
      chk("t4_requeue_id", 64'(owner_id), 64'd0);
      wait_gnt(40, n, lz);
      chk("t4_regrant0", 64'(gnt), 64'h1);

      // asynchronous reset during OWN
      tick(5);
      chk("t5_led_before", 64'(led_out), 64'h0000_00FF);
      rstn = 1'b0;
      #1;
      chk("t5_rst_gnt", 64'(gnt), 64'd0);
      chk("t5_rst_led", 64'(led_out), 64'd0);
      chk("t5_rst_vld", 64'(owner_vld), 64'd0);
      chk("t5_rst_id", 64'(owner_id), 64'd0);
      tick(2);
      rstn = 1'b1;
      req = 4'b1111;
      tick(1);
      chk("t5_first_id", 64'(owner_id), 64'd0);
      wait_gnt(40, n, lz);
      chk("t5_gnt0", 64'(gnt), 64'h1);
      tick(HOLD + 5);
      req = 4'b1110;
      tick(1);
      chk("t5_next_id", 64'(owner_id), 64'd1);
      chk("t5_rel_gnt", 64'(gnt), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/leddisplay_arbiter.md
Name: leddisplay_arbiter

Overview:
- Shares one multi-digit LED display between REQ_N requesters (for example the user design, a self-test pattern and a debug monitor).
- Grants the display round-robin and enforces a minimum and a maximum ownership time.
- Inserts a blank interval between owners so no mixed frame is shown.
- Drives the NUM*8-bit segment bus that feeds the serial LED display driver, which then shifts it out to the 74HC595 chain.

Parameters:
- NUM, 4, number of digits; each digit is 8 segment bits.
- REQ_N, 4, number of requesters (2..8).
- HOLD_CYCLES, 1000, minimum clk cycles an owner keeps the display.
- MAX_CYCLES, 100000, ownership time after which the owner is pre-empted if another requester is waiting (must be greater than HOLD_CYCLES).
- BLANK_CYCLES, 16, clk cycles the all-off frame is shown between owners (at least 1).

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; asynchronous assert, active low.
- req  in  REQ_N  per-requester display request (level).
- frame_in  in  REQ_N*NUM*8  per-requester frame; requester k uses bits [k*NUM*8 +: NUM*8].
- gnt  out  REQ_N  one-hot grant; all zero when no requester is granted.
- owner_id  out  3  index of the current or pending owner; valid when owner_vld=1.
- owner_vld  out  1  high in BLANK and OWN states.
- led_out  out  NUM*8  frame to the display driver, registered.

Behaviour:
- Reset:
  - state=IDLE, gnt=0, owner_vld=0, owner_id=0, led_out=0 (all segments off).
  - RR pointer=REQ_N-1, so req[0] wins first. Counters are cleared.
  - Reset asserted at any time aborts immediately to these values.
- Round-robin winner:
  - Search starts at last_owner+1 modulo REQ_N and takes the first set req bit.
  - The previous owner is considered last.
- IDLE:
  - led_out=0.
  - If any req is set: latch winner into owner_id, set owner_vld=1, clear blank_cnt, go to BLANK on the next clk.
- BLANK:
  - led_out=0, gnt=0.
  - blank_cnt increments each cycle.
  - When blank_cnt==BLANK_CYCLES-1: go to OWN, assert gnt[owner_id], clear hold_cnt.
  - If req[owner_id] drops during BLANK, the owner is still granted and then subject to the minimum hold.
- OWN:
  - While gnt is high, led_out <= frame_in of the owner every cycle (1-cycle latency from frame_in).
  - hold_cnt is 32 bits, increments each cycle and saturates.
  - Early drop: if req[owner] goes low while hold_cnt < HOLD_CYCLES, gnt drops on the next clk. led_out freezes at the last captured frame and the state stays OWN until hold_cnt reaches HOLD_CYCLES.
  - Release occurs at the first cycle where either:
    - req[owner]==0 and hold_cnt >= HOLD_CYCLES, or
    - hold_cnt >= MAX_CYCLES and another requester's req is set (pre-emption).
  - On release: gnt=0 on the next clk, last_owner=owner_id.
    - If a winner exists, go to BLANK with the new owner_id.
    - Otherwise go to IDLE with owner_vld=0 and led_out=0.
  - Pre-empted owner: if it still requests, it is re-queued at the lowest RR priority.
  - A single requester holding req forever is never pre-empted, because no other requester is waiting.
- Simultaneous events:
  - Release and new requests in the same cycle: new requests are included in the winner search.
  - The owner re-asserting req in the same cycle as an early-drop release is ignored.
- Invariants:
  - gnt is at most one-hot.
  - gnt is nonzero only in OWN.
  - led_out is always 0 in BLANK and IDLE.
- frame_in of non-owners is ignored.

Test Plan:
- Single requester: req=4'b0001, frame_in[31:0]=32'h3F06_5B4F.
  - Expected: BLANK for 16 cycles, then gnt=4'b0001.
  - led_out=32'h3F065B4F one cycle after gnt.
- Round-robin order: req=4'b0101 from reset, with both releasing after hold.
  - Expected grant order 0,2,0,2.
  - A 16-cycle led_out=0 gap between each owner.
- Early drop: owner 1 drops req at hold_cnt=10 with HOLD_CYCLES=1000.
  - Expected: gnt clears on the next clk.
  - led_out holds the last frame until cycle 1000, then goes to IDLE and led_out=0.
- Pre-emption: req0 held permanently, req3 rises at cycle 50.
  - Expected: owner 0 is released at hold_cnt=MAX_CYCLES, then BLANK, then gnt=4'b1000.
  - Owner 0 is re-granted after owner 3 releases.
- Reset mid-operation: pull rstn low during OWN.
  - Expected: gnt=0, led_out=0, owner_vld=0 immediately, without waiting for a clk.
  - After release, req=4'b1111 grants owner 0 first.
